// File: rtl/bp_profiler_pkg.sv
// Shared types for the profiler snapshot controller: FSM state encoding and header word layout.
package bp_profiler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_CLEAR  = 2'd3
    } prof_state_e;

    // Widest output word the header helper can build; callers truncate to their own width.
    localparam int hdr_max_width_lp = 64;

    // Header word: the sample sequence number in the low bits, zeros above it.
    function automatic logic [hdr_max_width_lp-1:0] make_header(input logic [hdr_max_width_lp-1:0] seq);
        return seq;
    endfunction

endpackage

// File: rtl/bsg_counter_clear_up.sv
// Free-running up counter with a synchronous clear that takes priority over counting.
module bsg_counter_clear_up #(
    parameter int width_p = 32
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               clear_i,
    input  logic               up_i,
    output logic [width_p-1:0] count_o
);

    logic [width_p-1:0] count_d;
    logic [width_p-1:0] count_q;

    // Next count: clear wins, otherwise increment when enabled.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (up_i) begin
            count_d = count_q + width_p'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/bp_stall_snapshot_ctrl.sv
// Profiling snapshot controller: latches a counter bank on trigger or periodic tick,
// streams header + counters with valid/ready handshaking, and sequences bank clears.
module bp_stall_snapshot_ctrl
    import bp_profiler_pkg::*;
#(
    parameter int width_p        = 32,
    parameter int num_counters_p = 8
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic                              cfg_en_i,
    input  logic [width_p-1:0]                cfg_interval_i,
    input  logic                              trigger_i,
    input  logic                              clear_i,
    input  logic [num_counters_p*width_p-1:0] counters_i,
    output logic                              counter_en_o,
    output logic                              counter_clear_o,
    output logic [width_p-1:0]                data_o,
    output logic                              v_o,
    input  logic                              ready_i,
    output logic                              last_o,
    output logic                              busy_o,
    output logic [width_p-1:0]                overrun_o
);

    localparam int idx_w_lp = $clog2(num_counters_p + 1);
    localparam logic [idx_w_lp-1:0] last_idx_lp = idx_w_lp'(num_counters_p - 1);

    logic [width_p-1:0]                timer_cnt;
    logic                              tick;
    logic                              snap_req;
    logic                              timer_clear;
    logic                              xfer;
    logic [width_p-1:0]                header_w;

    prof_state_e                       state_d, state_q;
    logic [idx_w_lp-1:0]               idx_d, idx_q;
    logic [width_p-1:0]                seq_d, seq_q;
    logic [width_p-1:0]                overrun_d, overrun_q;
    logic [width_p-1:0]                data_d, data_q;
    logic [num_counters_p*width_p-1:0] snap_d, snap_q;
    logic                              clr_pend_d, clr_pend_q;
    logic                              v_d, v_q;
    logic                              last_d, last_q;
    logic                              busy_d, busy_q;
    logic                              counter_clear_d, counter_clear_q;
    logic                              cfg_en_d, cfg_en_q;

    assign tick        = cfg_en_i && (cfg_interval_i != '0) && (timer_cnt == cfg_interval_i - width_p'(1));
    assign snap_req    = cfg_en_i && (trigger_i || tick);
    assign timer_clear = tick || (state_q == ST_CLEAR) || !cfg_en_i;
    assign xfer        = v_q && ready_i;
    assign header_w    = width_p'(make_header(64'(seq_q)));

    bsg_counter_clear_up #(
        .width_p (width_p)
    ) interval_timer (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (timer_clear),
        .up_i    (cfg_en_i),
        .count_o (timer_cnt)
    );

    // Next-state and next-output logic for the snapshot/stream/clear sequencer.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        seq_d      = seq_q;
        overrun_d  = overrun_q;
        data_d     = data_q;
        snap_d     = snap_q;
        clr_pend_d = clr_pend_q;
        v_d        = v_q;
        last_d     = last_q;
        cfg_en_d   = cfg_en_i;

        if ((state_q != ST_IDLE) && snap_req && (overrun_q != '1)) begin
            overrun_d = overrun_q + width_p'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (snap_req) begin
                    snap_d  = counters_i;
                    state_d = ST_STREAM;
                    idx_d   = '0;
                    v_d     = 1'b1;
                    last_d  = 1'b0;
                    data_d  = header_w;
                    if (clear_i) begin
                        clr_pend_d = 1'b1;
                    end
                end else if (clr_pend_q && cfg_en_q && !cfg_en_i) begin
                    state_d = ST_DRAIN;
                end else if (clear_i || clr_pend_q) begin
                    state_d    = ST_CLEAR;
                    clr_pend_d = 1'b0;
                end
            end
            ST_STREAM: begin
                if (clear_i) begin
                    clr_pend_d = 1'b1;
                end
                if (xfer) begin
                    if (last_q) begin
                        v_d    = 1'b0;
                        last_d = 1'b0;
                        idx_d  = '0;
                        seq_d  = seq_q + width_p'(1);
                        if (clr_pend_q || clear_i) begin
                            state_d    = ST_CLEAR;
                            clr_pend_d = 1'b0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        idx_d  = idx_q + idx_w_lp'(1);
                        data_d = snap_q[int'(idx_q)*width_p +: width_p];
                        last_d = (idx_q == last_idx_lp);
                    end
                end
            end
            ST_DRAIN: begin
                state_d    = ST_CLEAR;
                clr_pend_d = clear_i;
            end
            ST_CLEAR: begin
                state_d = ST_IDLE;
                if (clear_i) begin
                    clr_pend_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d          = (state_d != ST_IDLE);
        counter_clear_d = (state_d == ST_CLEAR);
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q         <= ST_IDLE;
            idx_q           <= '0;
            seq_q           <= '0;
            overrun_q       <= '0;
            data_q          <= '0;
            snap_q          <= '0;
            clr_pend_q      <= 1'b0;
            v_q             <= 1'b0;
            last_q          <= 1'b0;
            busy_q          <= 1'b0;
            counter_clear_q <= 1'b0;
            cfg_en_q        <= 1'b0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            seq_q           <= seq_d;
            overrun_q       <= overrun_d;
            data_q          <= data_d;
            snap_q          <= snap_d;
            clr_pend_q      <= clr_pend_d;
            v_q             <= v_d;
            last_q          <= last_d;
            busy_q          <= busy_d;
            counter_clear_q <= counter_clear_d;
            cfg_en_q        <= cfg_en_d;
        end
    end

    assign data_o          = data_q;
    assign v_o             = v_q;
    assign last_o          = last_q;
    assign busy_o          = busy_q;
    assign overrun_o       = overrun_q;
    assign counter_clear_o = counter_clear_q;
    assign counter_en_o    = cfg_en_i & ~counter_clear_q;

endmodule

// File: tb/tb_bp_stall_snapshot_ctrl.sv
// Self-checking bench for bp_stall_snapshot_ctrl: directed scenarios plus a randomized
// run compared against a word-queue reference model.
module tb_bp_stall_snapshot_ctrl;

    localparam int W = 16;
    localparam int N = 4;

    logic           clk_i = 1'b0;
    logic           reset_i;
    logic           cfg_en_i;
    logic [W-1:0]   cfg_interval_i;
    logic           trigger_i;
    logic           clear_i;
    logic [N*W-1:0] counters_i;
    logic           counter_en_o;
    logic           counter_clear_o;
    logic [W-1:0]   data_o;
    logic           v_o;
    logic           ready_i;
    logic           last_o;
    logic           busy_o;
    logic [W-1:0]   overrun_o;

    int total = 0;
    int bad   = 0;

    // Free-running clock.
    always #5 clk_i = ~clk_i;

    bp_stall_snapshot_ctrl #(
        .width_p        (W),
        .num_counters_p (N)
    ) dut (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .cfg_en_i        (cfg_en_i),
        .cfg_interval_i  (cfg_interval_i),
        .trigger_i       (trigger_i),
        .clear_i         (clear_i),
        .counters_i      (counters_i),
        .counter_en_o    (counter_en_o),
        .counter_clear_o (counter_clear_o),
        .data_o          (data_o),
        .v_o             (v_o),
        .ready_i         (ready_i),
        .last_o          (last_o),
        .busy_o          (busy_o),
        .overrun_o       (overrun_o)
    );

    // Reference model: words still owed to the consumer live in a queue.
    localparam int P_IDLE   = 0;
    localparam int P_STREAM = 1;
    localparam int P_DRAIN  = 2;
    localparam int P_CLEAR  = 3;

    int         m_phase;
    int         m_timer;
    int         m_ovr;
    bit         m_pend;
    bit         m_en_prev;
    logic [W-1:0] m_seq;
    logic [W-1:0] m_words[$];

    function automatic void model_reset();
        m_phase   = P_IDLE;
        m_timer   = 0;
        m_ovr     = 0;
        m_pend    = 1'b0;
        m_en_prev = 1'b0;
        m_seq     = '0;
        m_words.delete();
    endfunction

    // Advance the model by one clock using the inputs currently applied.
    function automatic void model_step();
        bit tick;
        bit req;
        bit xfer;
        int old_phase;
        tick = cfg_en_i && (cfg_interval_i != 0) && (m_timer == int'(cfg_interval_i) - 1);
        req  = cfg_en_i && (trigger_i || tick);
        xfer = (m_words.size() > 0) && ready_i;
        old_phase = m_phase;
        if (old_phase != P_IDLE && req && m_ovr < 65535) m_ovr++;
        case (old_phase)
            P_IDLE: begin
                if (req) begin
                    m_words.push_back(m_seq);
                    for (int k = 0; k < N; k++) m_words.push_back(counters_i[k*W +: W]);
                    m_phase = P_STREAM;
                    if (clear_i) m_pend = 1'b1;
                end else if (m_pend && m_en_prev && !cfg_en_i) begin
                    m_phase = P_DRAIN;
                end else if (clear_i || m_pend) begin
                    m_phase = P_CLEAR;
                    m_pend  = 1'b0;
                end
            end
            P_STREAM: begin
                if (clear_i) m_pend = 1'b1;
                if (xfer) begin
                    void'(m_words.pop_front());
                    if (m_words.size() == 0) begin
                        m_seq = m_seq + 1'b1;
                        if (m_pend) begin
                            m_phase = P_CLEAR;
                            m_pend  = 1'b0;
                        end else begin
                            m_phase = P_IDLE;
                        end
                    end
                end
            end
            P_DRAIN: begin
                m_phase = P_CLEAR;
                m_pend  = clear_i;
            end
            default: begin
                m_phase = P_IDLE;
                if (clear_i) m_pend = 1'b1;
            end
        endcase
        m_timer   = (!cfg_en_i || tick || old_phase == P_CLEAR) ? 0 : m_timer + 1;
        m_en_prev = cfg_en_i;
    endfunction

    task automatic cycle();
        model_step();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        reset_i        = 1'b1;
        cfg_en_i       = 1'b0;
        cfg_interval_i = '0;
        trigger_i      = 1'b0;
        clear_i        = 1'b0;
        ready_i        = 1'b0;
        counters_i     = '0;
        @(posedge clk_i);
        @(posedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        reset_i        = 1'b1;
        cfg_en_i       = 1'b1;
        cfg_interval_i = '0;
        trigger_i      = 1'b0;
        clear_i        = 1'b0;
        ready_i        = 1'b0;
        counters_i     = '0;
        #1;
        total++; if (v_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_v: got %0b want 0", v_o); end
        total++; if (last_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_last: got %0b want 0", last_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %0b want 0", busy_o); end
        total++; if (counter_clear_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_clear: got %0b want 0", counter_clear_o); end
        total++; if (overrun_o !== '0) begin bad++; $display("[TB] FAIL reset_overrun: got %0h want 0", overrun_o); end
        total++; if (counter_en_o !== 1'b1) begin bad++; $display("[TB] FAIL reset_en_hi: got %0b want 1", counter_en_o); end
        cfg_en_i = 1'b0;
        #1;
        total++; if (counter_en_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_en_lo: got %0b want 0", counter_en_o); end
        do_reset();
    endtask

    task automatic test_periodic();
        logic [W-1:0] c [N];
        int pos;
        int bursts;
        do_reset();
        for (int k = 0; k < N; k++) begin
            c[k] = W'((k + 1) * 16'h0111);
            counters_i[k*W +: W] = c[k];
        end
        cfg_interval_i = 10;
        cfg_en_i       = 1'b1;
        ready_i        = 1'b1;
        pos    = 0;
        bursts = 0;
        for (int i = 0; i < 40; i++) begin
            if (v_o) begin
                total++;
                if (pos == 0) begin
                    if (data_o !== W'(bursts)) begin bad++; $display("[TB] FAIL periodic_header: got %0h want %0h", data_o, bursts); end
                end else begin
                    if (data_o !== c[pos-1]) begin bad++; $display("[TB] FAIL periodic_word%0d: got %0h want %0h", pos, data_o, c[pos-1]); end
                end
                total++;
                if (last_o !== (pos == N)) begin bad++; $display("[TB] FAIL periodic_last%0d: got %0b want %0b", pos, last_o, pos == N); end
                pos++;
                if (pos == N + 1) begin
                    pos = 0;
                    bursts++;
                end
            end
            cycle();
        end
        total++; if (bursts != 3) begin bad++; $display("[TB] FAIL periodic_bursts: got %0d want 3", bursts); end
        cfg_en_i = 1'b0;
        for (int i = 0; i < 20 && busy_o; i++) cycle();
        total++; if (busy_o !== 1'b0) begin bad++; $display("[TB] FAIL periodic_idle: got %0b want 0", busy_o); end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] c [N];
        do_reset();
        cfg_en_i = 1'b1;
        ready_i  = 1'b0;
        for (int k = 0; k < N; k++) begin
            c[k] = W'($urandom());
            counters_i[k*W +: W] = c[k];
        end
        trigger_i = 1'b1;
        cycle();
        trigger_i  = 1'b0;
        counters_i = {$urandom(), $urandom()};
        for (int i = 0; i < 20; i++) begin
            total++;
            if (v_o !== 1'b1 || data_o !== '0 || last_o !== 1'b0) begin
                bad++; $display("[TB] FAIL stall_hold%0d: got v=%0b d=%0h l=%0b want v=1 d=0 l=0", i, v_o, data_o, last_o);
            end
            counters_i = {$urandom(), $urandom()};
            cycle();
        end
        ready_i = 1'b1;
        for (int p = 0; p <= N; p++) begin
            total++;
            if (v_o !== 1'b1 || data_o !== ((p == 0) ? W'(0) : c[p-1]) || last_o !== (p == N)) begin
                bad++; $display("[TB] FAIL stall_word%0d: got v=%0b d=%0h l=%0b want d=%0h l=%0b",
                                p, v_o, data_o, last_o, (p == 0) ? W'(0) : c[p-1], p == N);
            end
            cycle();
        end
        total++; if (v_o !== 1'b0) begin bad++; $display("[TB] FAIL stall_done: got %0b want 0", v_o); end
    endtask

    task automatic test_overrun();
        int vcount;
        int lcount;
        do_reset();
        cfg_en_i = 1'b1;
        ready_i  = 1'b1;
        vcount = 0;
        lcount = 0;
        for (int i = 0; i < 12; i++) begin
            if (v_o) vcount++;
            if (v_o && last_o) lcount++;
            trigger_i = (i <= 3);
            cycle();
        end
        trigger_i = 1'b0;
        total++; if (overrun_o !== W'(3)) begin bad++; $display("[TB] FAIL overrun_count: got %0d want 3", overrun_o); end
        total++; if (vcount != N + 1) begin bad++; $display("[TB] FAIL overrun_words: got %0d want %0d", vcount, N + 1); end
        total++; if (lcount != 1) begin bad++; $display("[TB] FAIL overrun_bursts: got %0d want 1", lcount); end
    endtask

    task automatic test_clear_mid_stream();
        int last_cyc;
        int clr_cyc;
        int pulses;
        do_reset();
        cfg_en_i = 1'b1;
        ready_i  = 1'b1;
        last_cyc = -1;
        clr_cyc  = -1;
        pulses   = 0;
        for (int i = 0; i < 12; i++) begin
            if (v_o && ready_i && last_o) last_cyc = i;
            if (counter_clear_o) begin
                pulses++;
                clr_cyc = i;
                total++;
                if (counter_en_o !== 1'b0) begin bad++; $display("[TB] FAIL midclr_en_gate: got %0b want 0", counter_en_o); end
            end
            trigger_i = (i == 0);
            clear_i   = (i == 2);
            cycle();
        end
        trigger_i = 1'b0;
        clear_i   = 1'b0;
        total++; if (last_cyc != N + 1) begin bad++; $display("[TB] FAIL midclr_last_cycle: got %0d want %0d", last_cyc, N + 1); end
        total++; if (pulses != 1) begin bad++; $display("[TB] FAIL midclr_pulses: got %0d want 1", pulses); end
        total++; if (clr_cyc != last_cyc + 1) begin bad++; $display("[TB] FAIL midclr_pulse_cycle: got %0d want %0d", clr_cyc, last_cyc + 1); end
    endtask

    task automatic test_trigger_and_clear();
        int last_cyc;
        int clr_cyc;
        int pulses;
        do_reset();
        cfg_en_i = 1'b1;
        ready_i  = 1'b1;
        last_cyc = -1;
        clr_cyc  = -1;
        pulses   = 0;
        for (int i = 0; i < 12; i++) begin
            if (v_o && ready_i && last_o) last_cyc = i;
            if (counter_clear_o) begin
                pulses++;
                clr_cyc = i;
            end
            trigger_i = (i == 0);
            clear_i   = (i == 0);
            cycle();
        end
        trigger_i = 1'b0;
        clear_i   = 1'b0;
        total++; if (last_cyc != N + 1) begin bad++; $display("[TB] FAIL trigclr_last_cycle: got %0d want %0d", last_cyc, N + 1); end
        total++; if (pulses != 1) begin bad++; $display("[TB] FAIL trigclr_pulses: got %0d want 1", pulses); end
        total++; if (clr_cyc != N + 2) begin bad++; $display("[TB] FAIL trigclr_pulse_cycle: got %0d want %0d", clr_cyc, N + 2); end
    endtask

    task automatic test_reset_mid_stream();
        do_reset();
        cfg_en_i   = 1'b1;
        ready_i    = 1'b1;
        counters_i = {$urandom(), $urandom()};
        trigger_i  = 1'b1;
        cycle();
        trigger_i = 1'b0;
        for (int i = 0; i < N + 1; i++) cycle();
        trigger_i = 1'b1;
        cycle();
        trigger_i = 1'b0;
        total++; if (data_o !== W'(1)) begin bad++; $display("[TB] FAIL rst_mid_seq1: got %0h want 1", data_o); end
        cycle();
        cycle();
        reset_i = 1'b1;
        #1;
        total++; if (v_o !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid_v: got %0b want 0", v_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid_busy: got %0b want 0", busy_o); end
        model_reset();
        @(posedge clk_i);
        @(negedge clk_i);
        reset_i   = 1'b0;
        trigger_i = 1'b1;
        cycle();
        trigger_i = 1'b0;
        total++; if (v_o !== 1'b1 || data_o !== '0) begin bad++; $display("[TB] FAIL rst_mid_seq0: got v=%0b d=%0h want v=1 d=0", v_o, data_o); end
        for (int i = 0; i < N + 1; i++) cycle();
    endtask

    task automatic test_random();
        logic [W-1:0] intervals [5];
        bit exp_v;
        intervals[0] = 0; intervals[1] = 1; intervals[2] = 3; intervals[3] = 7; intervals[4] = 12;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) cfg_interval_i = intervals[$urandom_range(0, 4)];
            cfg_en_i   = ($urandom_range(0, 19) != 0);
            trigger_i  = ($urandom_range(0, 9) == 0);
            clear_i    = ($urandom_range(0, 24) == 0);
            ready_i    = ($urandom_range(0, 9) < 7);
            counters_i = {$urandom(), $urandom()};
            #1;
            exp_v = (m_words.size() > 0);
            total++; if (v_o !== exp_v) begin bad++; $display("[TB] FAIL rnd_v@%0d: got %0b want %0b", i, v_o, exp_v); end
            total++; if (last_o !== (m_words.size() == 1)) begin bad++; $display("[TB] FAIL rnd_last@%0d: got %0b want %0b", i, last_o, m_words.size() == 1); end
            if (exp_v) begin
                total++; if (data_o !== m_words[0]) begin bad++; $display("[TB] FAIL rnd_data@%0d: got %0h want %0h", i, data_o, m_words[0]); end
            end
            total++; if (busy_o !== (m_phase != P_IDLE)) begin bad++; $display("[TB] FAIL rnd_busy@%0d: got %0b want %0b", i, busy_o, m_phase != P_IDLE); end
            total++; if (counter_clear_o !== (m_phase == P_CLEAR)) begin bad++; $display("[TB] FAIL rnd_clear@%0d: got %0b want %0b", i, counter_clear_o, m_phase == P_CLEAR); end
            total++; if (counter_en_o !== (cfg_en_i && m_phase != P_CLEAR)) begin bad++; $display("[TB] FAIL rnd_en@%0d: got %0b want %0b", i, counter_en_o, cfg_en_i && m_phase != P_CLEAR); end
            total++; if (overrun_o !== W'(m_ovr)) begin bad++; $display("[TB] FAIL rnd_overrun@%0d: got %0d want %0d", i, overrun_o, m_ovr); end
            cycle();
        end
    endtask

    // Run every scenario in order, then report.
    initial begin
        test_reset();
        test_periodic();
        test_backpressure();
        test_overrun();
        test_clear_mid_stream();
        test_trigger_and_clear();
        test_reset_mid_stream();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bp_stall_snapshot_ctrl.md
BP_STALL_SNAPSHOT_CTRL -- requirements
Module: bp_stall_snapshot_ctrl

Interface
REQ-001 Parameter width_p, default 32, width of each counter, the sequence number and the output word.
REQ-002 Parameter num_counters_p, default 8, number of counters in the bank; SHALL be at least 1.
REQ-003 Port clk_i, input, 1, the single clock.
REQ-004 Port reset_i, input, 1, reset; asynchronous, active-high.
REQ-005 Port cfg_en_i, input, 1, profiling enable.
REQ-006 Port cfg_interval_i, input, width_p, periodic sample period in cycles; 0 disables periodic sampling.
REQ-007 Port trigger_i, input, 1, manual snapshot request pulse.
REQ-008 Port clear_i, input, 1, request to clear the counter bank.
REQ-009 Port counters_i, input, num_counters_p*width_p, live counter values; counter k occupies bits [k*width_p +: width_p].
REQ-010 Port counter_en_o, output, 1, drives the counter-bank enable.
REQ-011 Port counter_clear_o, output, 1, drives the counter-bank clear.
REQ-012 Port data_o, output, width_p, stream word.
REQ-013 Port v_o, output, 1, data_o valid.
REQ-014 Port ready_i, input, 1, consumer ready.
REQ-015 Port last_o, output, 1, marks the final word of a sample.
REQ-016 Port busy_o, output, 1, high whenever the state is not IDLE.
REQ-017 Port overrun_o, output, width_p, count of dropped snapshot requests.

Function
REQ-018 The FSM SHALL have four states: IDLE, STREAM, DRAIN and CLEAR.
REQ-019 A snapshot request is trigger_i, or an interval tick, while cfg_en_i=1.
- Tick: the interval timer equals cfg_interval_i-1 and cfg_interval_i!=0.
- Timer behaviour: counts while cfg_en_i=1, wraps to 0 on a tick, and is held at 0 while cfg_en_i=0.
REQ-020 IDLE with a snapshot request in cycle t:
- all counters_i are latched into the snapshot register at the end of cycle t;
- the FSM goes to STREAM;
- v_o=1 from cycle t+1.
REQ-021 STREAM output order, num_counters_p+1 words:
- first a header equal to the sequence number;
- then counter 0 through counter num_counters_p-1;
- last_o=1 only with the final counter word.
REQ-022 A word transfers only when v_o&ready_i; data_o and last_o SHALL remain stable while v_o&~ready_i.
REQ-023 When the last word transfers:
- the sequence number increments, modulo 2^width_p;
- the FSM goes to CLEAR if a clear is pending, else to IDLE.
REQ-024 A snapshot request arriving while not in IDLE SHALL be dropped, and overrun_o incremented, saturating at 2^width_p-1.
REQ-025 clear_i in IDLE, with no simultaneous snapshot request, SHALL move the FSM to CLEAR.
REQ-026 CLEAR SHALL assert counter_clear_o for exactly one cycle, then return to IDLE; the interval timer is reset to 0 in the same cycle.
REQ-027 clear_i in any non-IDLE state SHALL set a pending-clear flag; the pending clear executes after the stream completes.
REQ-028 A snapshot request and clear_i in the same IDLE cycle: the snapshot wins and the clear becomes pending.
REQ-029 counter_en_o = cfg_en_i & ~counter_clear_o.
REQ-030 cfg_en_i falling during STREAM SHALL NOT abort the stream.
REQ-031 DRAIN: reserved; the FSM SHALL enter it when cfg_en_i falls in IDLE while a clear is pending, and go to CLEAR next cycle.

Reset
REQ-032 On reset_i the following SHALL be 0 / deasserted: state=IDLE, interval timer, sequence number, overrun_o, pending-clear flag, snapshot register, v_o, last_o, busy_o, counter_clear_o.
REQ-033 Reset asserted mid-stream SHALL immediately drop v_o with no partial completion.
REQ-034 counter_en_o SHALL follow cfg_en_i after reset.

Structure
REQ-035 The FSM state enum and the header word layout SHALL live in a shared package, bp_profiler_pkg.
REQ-036 The word index (clog2(num_counters_p+1) bits) and the sequence number SHALL be local registers.
REQ-037 The interval timer SHALL be a single sub-module, bsg_counter_clear_up, cleared on tick, on CLEAR, or when ~cfg_en_i.

Verification
REQ-038 cfg_interval_i=10, cfg_en_i=1, ready_i=1, 4 counters -> 5-word bursts every 10 cycles; headers 0,1,2; last_o on the 5th word only.
REQ-039 trigger_i, then ready_i=0 for 20 cycles -> data_o held equal to the header; then ready_i=1 -> counter values exactly as latched at the trigger cycle.
REQ-040 trigger_i, then 3 more triggers during STREAM -> overrun_o=3; a single burst.
REQ-041 clear_i mid-stream -> counter_clear_o a single-cycle pulse one cycle after last_o transfers; no pulse before.
REQ-042 trigger_i and clear_i in the same IDLE cycle -> the burst completes, then counter_clear_o pulses once.
REQ-043 reset_i asserted during word 2 -> v_o=0 at once; sequence number 0 on the next sample.
